dmem_responder: RTL

- Data-memory responder at the far end of the MEM-stage access interface; the pipeline initiates, this block serves.
- Accepts one load or store per handshake using the MEM-stage control encoding (mem_wren, byte_num, ld_unsigned).
- Performs byte-lane alignment, applies a configurable wait-state latency, and returns aligned, sign/zero-extended load data with a one-cycle response pulse.
- The MEM stage stalls from request until response.

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_load_align.sv | 33 +++
 rtl/dmem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: MEM-stage size encodings, capture record, FSM states.
// Pure declarations; no latency or backpressure of its own.
package dmem_responder_pkg;

  localparam logic [3:0] BN_BYTE = 4'b0001;
  localparam logic [3:0] BN_HALF = 4'b0011;
  localparam logic [3:0] BN_WORD = 4'b1111;

  typedef struct packed {
    logic        mem_wren;
    logic        ld_unsigned;
    logic [3:0]  byte_num;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // Unknown size encodings are treated as a full word.
  function automatic logic [3:0] legal_bn(input logic [3:0] bn);
    return (bn == BN_BYTE || bn == BN_HALF) ? bn : BN_WORD;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: shifts a memory word down by the byte offset and sign/zero-extends by access size.
// Combinational, zero latency; no flow control.
module dmem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [3:0]  byte_num,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        sbit;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    sbit    = 1'b0;
    ld_data = shifted;
    case (byte_num)
      BN_BYTE: begin
        sbit    = ~ld_unsigned & shifted[7];
        ld_data = {{24{sbit}}, shifted[7:0]};
      end
      BN_HALF: begin
        sbit    = ~ld_unsigned & shifted[15];
        ld_data = {{16{sbit}}, shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage loads/stores; optional fault reporting under MISALIGN_CHECK_EN.
// Latency: response pulse WAIT_CYCLES+1 cycles after the accept cycle; one request per WAIT_CYCLES+2 cycles.
// Backpressure: o_req_ready is high only in IDLE; there is no response-side backpressure.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    DEPTH_WORDS = 2048,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_mem_wren,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byte_num,
  input  logic        i_ld_unsigned,
  output logic        o_rsp_valid,
  output logic [31:0] o_ld_data
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        o_misaligned
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [31:0]      mem [DEPTH_WORDS];
  dmem_state_e      state;
  logic [CNT_W-1:0] wait_cnt;
  dmem_req_t        req_q;
  dmem_req_t        acc;
  logic             enter_resp;
  logic             fault;
  logic             do_write;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       bn;
  logic [3:0]       wmask;
  logic [31:0]      wdata_sh;
  logic [31:0]      ld_aligned;

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  always_comb begin
    acc = (state == IDLE) ? '{mem_wren:    i_mem_wren,
                              ld_unsigned: i_ld_unsigned,
                              byte_num:    i_byte_num,
                              addr:        i_addr,
                              wdata:       i_wdata} : req_q;
    enter_resp = 1'b0;
    if (state == IDLE)      enter_resp = i_req_valid && (WAIT_CYCLES == 0);
    else if (state == WAIT) enter_resp = (wait_cnt == '0);
    idx      = acc.addr[IDX_W+1:2];
    off      = acc.addr[1:0];
    bn       = legal_bn(acc.byte_num);
    wmask    = bn << off;
    wdata_sh = acc.wdata << {off, 3'b000};
`ifdef MISALIGN_CHECK_EN
    fault = (acc.byte_num != bn) || (bn == BN_HALF && off[0]) || (bn == BN_WORD && off != 2'd0);
`else
    fault = 1'b0;
`endif
    do_write = enter_resp && acc.mem_wren && !fault && i_rst_n;
  end

  dmem_load_align u_align (
    .rdata       (mem[idx]),
    .offset      (off),
    .byte_num    (bn),
    .ld_unsigned (acc.ld_unsigned),
    .ld_data     (ld_aligned)
  );

  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_q       <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_ld_data   <= '0;
`ifdef MISALIGN_CHECK_EN
      o_misaligned <= 1'b0;
`endif
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_q       <= acc;
            o_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
      // Load data is captured on the RESP edge and held until the next one.
      if (enter_resp) o_ld_data <= (acc.mem_wren || fault) ? '0 : ld_aligned;
`ifdef MISALIGN_CHECK_EN
      o_misaligned <= enter_resp && fault;
`endif
    end
  end

endmodule
